div_arb: RTL and testbench
==========================

DIV_ARB -- requirements
Module: div_arb

Interface
REQ-001 Parameter LAT, default 32: latency of the attached pipelined divider, in cycles from operand sampling to quotient valid.
REQ-002 Parameter MAX_OUT, default 8: maximum in-flight divisions per channel.
REQ-003 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous assert, active-low.
REQ-005 req0_valid / req1_valid  input  1  Channel k has a division request.
REQ-006 req0_ready / req1_ready  output  1  Channel k request accepted this cycle.
REQ-007 req0_dataa, req0_datab / req1_dataa, req1_datab  input  32  Channel k dividend and divisor.
REQ-008 div_dataa, div_datab  output  32  Operands to the divider, sampled by it on every rising edge.
REQ-009 div_quotient  input  32  Divider output, valid LAT cycles after operand sampling.
REQ-010 rsp0_valid / rsp1_valid  output  1  One-cycle pulse: channel k result present.
REQ-011 rsp_quot  output  32  Result quotient, shared by both channels.
REQ-012 rsp_dbz  output  1  Result came from a zero divisor.
REQ-013 idle  output  1  High when nothing is in flight.

Function
REQ-014 Channel k is eligible when reqk_valid=1 and outstanding count cnt_k < MAX_OUT.
REQ-015 At most one channel is granted per cycle; reqk_ready equals grant_k, which is combinational from valid, cnt and the round-robin pointer.
REQ-016 If exactly one channel is eligible, that channel is granted regardless of the pointer.
REQ-017 If both channels are eligible, the channel named by the pointer is granted.
REQ-018 After a grant to channel k, the pointer moves to the other channel; with no grant, the pointer holds.
REQ-019 div_dataa/div_datab carry the granted channel's operands, or zero when nothing is granted.
REQ-020 A tag pipeline of depth LAT carries {valid, channel, dbz} per slot, with dbz = (datab==0).
REQ-021 An entry inserted at acceptance in cycle c emerges in cycle c+LAT, aligned with div_quotient.
REQ-022 When the emerging entry is valid, rspk_valid=1 for exactly that cycle, and only for the tagged channel.
REQ-023 rsp_quot equals div_quotient, or 32'hFFFF_FFFF when dbz=1; rsp_quot and rsp_dbz are 0 when no response is present.
REQ-024 Responses have no backpressure; the requester shall consume the result in the cycle it is presented.
REQ-025 cnt_k increments on accept and decrements on response; a simultaneous accept and response leaves it unchanged. cnt_k never exceeds MAX_OUT and never wraps below 0.
REQ-026 A channel with cnt_k = MAX_OUT and a response emerging in the same cycle is still ineligible that cycle, because eligibility uses the registered cnt.
REQ-027 idle=1 iff cnt_0=0, cnt_1=0 and every tag slot is invalid.
REQ-028 Responses return in acceptance order, with a throughput of one division per cycle.

Reset
REQ-029 While rst_n=0, the following are cleared: all tag slots, cnt_0, cnt_1, and the pointer (which clears to channel 0).
REQ-030 While rst_n=0, the outputs are: readies 0, rsp*_valid 0, rsp_quot 0, rsp_dbz 0, idle 1, div operands 0.
REQ-031 On reset mid-operation, in-flight entries are discarded with no response, and the first grant after release goes to channel 0 when both channels request.

Verification
REQ-032 Single channel: ch0 issues 100/7 at cycle 5 -> rsp0_valid in cycle 37, rsp_quot=14, rsp_dbz=0, and idle=1 from cycle 38.
REQ-033 Contention: both channels valid continuously, ch0 operands 50/5 and ch1 operands 9/3 -> grants alternate 0,1,0,1..., and responses alternate with quotients 10 and 3, one per cycle.
REQ-034 Divide by zero: ch1 issues 123/0 -> rsp1_valid after LAT cycles, rsp_quot=FFFF_FFFF, rsp_dbz=1.
REQ-035 Credit limit: ch0 valid for 20 cycles with ch1 idle -> 8 accepts, req0_ready=0 until the first response, then accepts resume one per response, and cnt_0 stays at most 8.
REQ-036 Reset mid-flight: 5 requests in flight, rst_n low 1 cycle -> no rsp pulses afterward, idle=1, and the next request completes in exactly LAT cycles.

Source files
------------

// File: rtl/div_arb.sv
// Two-channel front end for a shared pipelined divider.
// A round-robin arbiter picks one request per cycle, limited by per-channel
// credits. A tag pipeline that matches the divider latency routes each
// quotient back to its channel and flags divide-by-zero results.
module div_arb #(
  parameter int LAT     = 32,
  parameter int MAX_OUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_dataa,
  input  logic [31:0] req0_datab,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_dataa,
  input  logic [31:0] req1_datab,
  output logic [31:0] div_dataa,
  output logic [31:0] div_datab,
  input  logic [31:0] div_quotient,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_quot,
  output logic        rsp_dbz,
  output logic        idle
);

  // The credit counter must be able to hold MAX_OUT itself.
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0]  r_cnt0;
  logic [CW-1:0]  r_cnt1;
  logic           r_ptr;       // 0: channel 0 wins a tie, 1: channel 1 wins
  logic [LAT-1:0] r_tag_vld;
  logic [LAT-1:0] r_tag_ch;
  logic [LAT-1:0] r_tag_dbz;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_dbz_in;
  logic [31:0] w_opa;
  logic [31:0] w_opb;
  logic        w_rsp_vld;
  logic        w_rsp_ch;
  logic        w_rsp_dbz;
  logic        w_rsp0;
  logic        w_rsp1;

  // Credits move up on accept and down on response; both at once cancel.
  function automatic logic [CW-1:0] f_next_cnt(input logic [CW-1:0] cnt,
                                               input logic          acc,
                                               input logic          rsp);
    logic [CW-1:0] res;
    res = cnt;
    if (acc && !rsp && (cnt < CW'(MAX_OUT))) begin
      res = cnt + CW'(1);
    end else if (rsp && !acc && (cnt != '0)) begin
      res = cnt - CW'(1);
    end
    return res;
  endfunction

  // Eligibility uses the registered credit count, so a channel sitting at
  // MAX_OUT stays blocked even in the cycle its oldest result returns.
  assign w_elig0 = req0_valid && (r_cnt0 < CW'(MAX_OUT));
  assign w_elig1 = req1_valid && (r_cnt1 < CW'(MAX_OUT));

  // A lone eligible channel wins outright; on a tie the pointer decides.
  // Grants are held off while reset is asserted.
  assign w_grant0 = rst_n && w_elig0 && (!w_elig1 || (r_ptr == 1'b0));
  assign w_grant1 = rst_n && w_elig1 && (!w_elig0 || (r_ptr == 1'b1));
  assign w_accept = w_grant0 || w_grant1;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Route the winner's operands to the divider, zero when idle.
  // NOTE: every output of a combinational block gets a default on entry so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_opa    = '0;
    w_opb    = '0;
    w_dbz_in = 1'b0;
    if (w_grant0) begin
      w_opa    = req0_dataa;
      w_opb    = req0_datab;
      w_dbz_in = (req0_datab == '0);
    end else if (w_grant1) begin
      w_opa    = req1_dataa;
      w_opb    = req1_datab;
      w_dbz_in = (req1_datab == '0);
    end
  end

  assign div_dataa = w_opa;
  assign div_datab = w_opb;

  // The oldest tag slot lines up with the quotient currently leaving the divider.
  assign w_rsp_vld = r_tag_vld[LAT-1];
  assign w_rsp_ch  = r_tag_ch[LAT-1];
  assign w_rsp_dbz = r_tag_dbz[LAT-1];
  assign w_rsp0    = w_rsp_vld && !w_rsp_ch;
  assign w_rsp1    = w_rsp_vld && w_rsp_ch;

  assign rsp0_valid = w_rsp0;
  assign rsp1_valid = w_rsp1;
  assign rsp_dbz    = w_rsp_vld && w_rsp_dbz;
  assign rsp_quot   = !w_rsp_vld ? 32'h0 :
                      (w_rsp_dbz ? 32'hFFFF_FFFF : div_quotient);

  assign idle = (r_cnt0 == '0) && (r_cnt1 == '0) && (r_tag_vld == '0);

  // Tag pipeline: slot 0 takes the new acceptance, each slot shifts one per cycle.
  // NOTE: the tag slots are a shift register rather than a RAM, and they are
  // reset on purpose, because a stale valid bit would emit a phantom response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_ch  <= '0;
      r_tag_dbz <= '0;
    end else begin
      // NOTE: non-blocking assignments, so each slot takes its neighbour's
      // value from before this edge and the whole line shifts in lockstep.
      r_tag_vld[0] <= w_accept;
      r_tag_ch[0]  <= w_grant1;
      r_tag_dbz[0] <= w_accept && w_dbz_in;
      for (int i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_ch[i]  <= r_tag_ch[i-1];
        r_tag_dbz[i] <= r_tag_dbz[i-1];
      end
    end
  end

  // Credit counters and the round-robin pointer, which flips away from each winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_ptr  <= 1'b0;
    end else begin
      r_cnt0 <= f_next_cnt(r_cnt0, w_grant0, w_rsp0);
      r_cnt1 <= f_next_cnt(r_cnt1, w_grant1, w_rsp1);
      if (w_grant0) begin
        r_ptr <= 1'b1;
      end else if (w_grant1) begin
        r_ptr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_arb.sv
// Directed bench for div_arb, with a behavioural pipelined divider attached.
// Inputs change 1 time unit after each rising edge. Outputs are sampled 2
// time units later, well clear of both clock edges.
module tb_div_arb;

  localparam int LAT     = 32;
  localparam int MAX_OUT = 8;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_dataa, req0_datab, req1_dataa, req1_datab;
  logic [31:0] div_dataa, div_datab, div_quotient;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_quot;
  logic        rsp_dbz;
  logic        idle;

  int total;
  int bad;
  int stray;
  int acc20;
  int acc_all;
  int mc;
  int max_mc;

  logic [31:0] div_pipe [LAT];

  div_arb #(.LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_dataa  (req0_dataa),
    .req0_datab  (req0_datab),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_dataa  (req1_dataa),
    .req1_datab  (req1_datab),
    .div_dataa   (div_dataa),
    .div_datab   (div_datab),
    .div_quotient(div_quotient),
    .rsp0_valid  (rsp0_valid),
    .rsp1_valid  (rsp1_valid),
    .rsp_quot    (rsp_quot),
    .rsp_dbz     (rsp_dbz),
    .idle        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External divider: samples operands on every edge, quotient LAT cycles later.
  always @(posedge clk) begin
    div_pipe[0] <= (div_datab == 32'h0) ? 32'h0 : div_dataa / div_datab;
    for (int i = 1; i < LAT; i++) div_pipe[i] <= div_pipe[i-1];
  end
  assign div_quotient = div_pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_dataa = 32'd1; req0_datab = 32'd1;
    req1_valid = 1'b1; req1_dataa = 32'd2; req1_datab = 32'd1;

    // ---- reset state, with requests present ----
    go(); go(); #2;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_rsp0",   rsp0_valid, 0);
    check("rst_rsp1",   rsp1_valid, 0);
    check("rst_quot",   rsp_quot,   0);
    check("rst_dbz",    rsp_dbz,    0);
    check("rst_idle",   idle,       1);
    check("rst_diva",   div_dataa,  0);
    check("rst_divb",   div_datab,  0);

    req0_valid = 1'b0; req1_valid = 1'b0;
    go(); rst_n = 1'b1;
    go(); go();

    // ---- single channel: ch0 100/7 ----
    go();
    req0_valid = 1'b1; req0_dataa = 32'd100; req0_datab = 32'd7;
    #2;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    check("t1_diva",   div_dataa,  100);
    check("t1_divb",   div_datab,  7);
    stray = 0;
    for (int i = 1; i <= LAT + 1; i++) begin
      go();
      req0_valid = 1'b0;
      #2;
      if (i < LAT) stray += int'(rsp0_valid) + int'(rsp1_valid);
      if (i == 10) check("t1_busy", idle, 0);
      if (i == LAT) begin
        check("t1_rsp0", rsp0_valid, 1);
        check("t1_rsp1", rsp1_valid, 0);
        check("t1_quot", rsp_quot,   14);
        check("t1_dbz",  rsp_dbz,    0);
        check("t1_idle_at_rsp", idle, 0);
      end
      if (i == LAT + 1) begin
        check("t1_idle_after", idle,       1);
        check("t1_rsp0_after", rsp0_valid, 0);
        check("t1_quot_after", rsp_quot,   0);
      end
    end
    check("t1_stray", stray, 0);

    // ---- divide by zero on ch1: 123/0 (pointer points at ch1 now) ----
    go();
    req1_valid = 1'b1; req1_dataa = 32'd123; req1_datab = 32'd0;
    #2;
    check("t2_ready1", req1_ready, 1);
    check("t2_diva",   div_dataa,  123);
    stray = 0;
    for (int i = 1; i <= LAT; i++) begin
      go();
      req1_valid = 1'b0;
      #2;
      if (i < LAT) stray += int'(rsp0_valid) + int'(rsp1_valid);
      if (i == LAT) begin
        check("t2_rsp1", rsp1_valid, 1);
        check("t2_rsp0", rsp0_valid, 0);
        check("t2_quot", rsp_quot,   32'hFFFF_FFFF);
        check("t2_dbz",  rsp_dbz,    1);
      end
    end
    check("t2_stray", stray, 0);

    // ---- contention: ch0 50/5, ch1 9/3, both valid for 10 cycles ----
    req0_dataa = 32'd50; req0_datab = 32'd5;
    req1_dataa = 32'd9;  req1_datab = 32'd3;
    stray = 0;
    for (int i = 0; i <= LAT + 10; i++) begin
      go();
      req0_valid = (i < 10);
      req1_valid = (i < 10);
      #2;
      if (i < 10) begin
        check($sformatf("t3_grant0_%0d", i), req0_ready, (i % 2 == 0));
        check($sformatf("t3_grant1_%0d", i), req1_ready, (i % 2 == 1));
        check($sformatf("t3_diva_%0d", i),   div_dataa,  (i % 2 == 0) ? 50 : 9);
      end
      if (i < LAT) stray += int'(rsp0_valid) + int'(rsp1_valid);
      if (i >= LAT && i < LAT + 10) begin
        check($sformatf("t3_rsp0_%0d", i), rsp0_valid, ((i - LAT) % 2 == 0));
        check($sformatf("t3_rsp1_%0d", i), rsp1_valid, ((i - LAT) % 2 == 1));
        check($sformatf("t3_quot_%0d", i), rsp_quot,   ((i - LAT) % 2 == 0) ? 10 : 3);
      end
      if (i == LAT + 10) begin
        check("t3_rsp_end", int'(rsp0_valid) + int'(rsp1_valid), 0);
        check("t3_idle",    idle, 1);
      end
    end
    check("t3_stray", stray, 0);

    // ---- credit limit: ch0 20/4 valid for 46 cycles, ch1 idle ----
    req0_dataa = 32'd20; req0_datab = 32'd4;
    acc20 = 0; acc_all = 0; mc = 0; max_mc = 0;
    for (int i = 0; i < 46; i++) begin
      go();
      req0_valid = 1'b1;
      #2;
      if (i < 20) acc20 += int'(req0_ready);
      acc_all += int'(req0_ready);
      mc = mc + int'(req0_ready) - int'(rsp0_valid);
      if (mc > max_mc) max_mc = mc;
      if (i == 7)  check("t4_ready_7", req0_ready, 1);
      if (i == 8)  check("t4_ready_8", req0_ready, 0);
      if (i == 32) begin
        check("t4_ready_32", req0_ready, 0);
        check("t4_rsp_32",   rsp0_valid, 1);
        check("t4_quot_32",  rsp_quot,   5);
      end
      if (i == 33) check("t4_ready_33", req0_ready, 1);
      if (i == 41) check("t4_ready_41", req0_ready, 0);
    end
    check("t4_acc20",   acc20,   8);
    check("t4_acc_all", acc_all, 16);
    check("t4_max_cnt", max_mc,  8);
    go();
    req0_valid = 1'b0;
    #2;
    mc = mc - int'(rsp0_valid);
    for (int k = 0; k < 200 && !idle; k++) begin
      go(); #2;
      mc = mc - int'(rsp0_valid);
    end
    check("t4_drain_idle", idle, 1);
    check("t4_drain_cnt",  mc,   0);

    // ---- reset mid-flight: 5 requests on ch0, then a 1-cycle reset ----
    req0_dataa = 32'd40; req0_datab = 32'd8;
    for (int i = 0; i < 5; i++) begin
      go();
      req0_valid = 1'b1;
      #2;
      check($sformatf("t5_acc_%0d", i), req0_ready, 1);
    end
    go();
    rst_n = 1'b0;
    req1_valid = 1'b1;
    #2;
    check("t5_rst_ready0", req0_ready, 0);
    check("t5_rst_ready1", req1_ready, 0);
    check("t5_rst_idle",   idle,       1);
    check("t5_rst_diva",   div_dataa,  0);
    go();
    rst_n = 1'b1;
    req0_dataa = 32'd77; req0_datab = 32'd7;
    req1_dataa = 32'd8;  req1_datab = 32'd2;
    #2;
    check("t5_grant0", req0_ready, 1);
    check("t5_grant1", req1_ready, 0);
    check("t5_diva",   div_dataa,  77);
    stray = 0;
    for (int i = 1; i <= LAT + 5; i++) begin
      go();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #2;
      if (i == LAT) begin
        check("t5_rsp0", rsp0_valid, 1);
        check("t5_rsp1", rsp1_valid, 0);
        check("t5_quot", rsp_quot,   11);
      end else begin
        stray += int'(rsp0_valid) + int'(rsp1_valid);
      end
    end
    check("t5_stray", stray, 0);
    check("t5_idle",  idle,  1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
